// File: rtl/sprite_motion_ctrl_if.sv
// Control and position bus between the VGA timing/switch side and sprite_motion_ctrl.
interface sprite_motion_ctrl_if;
    logic [9:0] vc;
    logic       mode;
    logic       pause;
    logic [1:0] speed;
    logic [3:0] fdiv;
    logic [7:0] sw;
    logic [9:0] x_org;
    logic [9:0] y_org;
    logic       dir_x;
    logic       dir_y;
    logic       upd;

    modport master (
        output vc, mode, pause, speed, fdiv, sw,
        input  x_org, y_org, dir_x, dir_y, upd
    );

    modport slave (
        input  vc, mode, pause, speed, fdiv, sw,
        output x_org, y_org, dir_x, dir_y, upd
    );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Once-per-frame sprite origin scheduler: auto bounce or switch position, committed in vblank.
// Define SPRITE_WRAP_EN to make auto mode wrap around the screen instead of bouncing.
module sprite_motion_ctrl #(
    parameter int unsigned HBP  = 144,
    parameter int unsigned VBP  = 31,
    parameter int unsigned HACT = 640,
    parameter int unsigned VACT = 480,
    parameter int unsigned W    = 240,
    parameter int unsigned H    = 160
) (
    input logic                 clk,
    input logic                 clr,
    sprite_motion_ctrl_if.slave bus
);

    localparam logic [9:0]  TICK_VC = 10'(VBP + VACT);
    localparam logic [10:0] XMAX    = 11'(HACT - W);
    localparam logic [10:0] YMAX    = 11'(VACT - H);

    // Origin must stay addressable by the 10-bit VGA counters.
    if (HBP + HACT > 1023 || VBP + VACT > 1023 || W > HACT || H > VACT) begin : g_bad_params
        $error("sprite_motion_ctrl: geometry parameters out of range");
    end

    typedef enum logic [1:0] {StWait, StCalcX, StCalcY, StCommit} state_t;

    state_t     state;
    logic [9:0] vc_q;
    logic [3:0] fcnt;
    logic       mode_q;
    logic [1:0] speed_q;
    logic [7:0] sw_q;
    logic [9:0] x_sh, y_sh;
    logic       dx_sh, dy_sh;
    logic [9:0] x_org_q, y_org_q;
    logic       dir_x_q, dir_y_q, upd_q;

    logic        tick;
    logic [10:0] cur_pos, max_pos, man_pos, step, sum;
    logic        cur_dir;
    logic [9:0]  nxt_pos;
    logic        nxt_dir;

    assign tick = (bus.vc == TICK_VC) && (vc_q != bus.vc);

    // One shared axis unit: CALC_Y works on y, every other state on x.
    always_comb begin
        cur_pos = (state == StCalcY) ? {1'b0, y_org_q} : {1'b0, x_org_q};
        cur_dir = (state == StCalcY) ? dir_y_q : dir_x_q;
        max_pos = (state == StCalcY) ? YMAX : XMAX;
        man_pos = (state == StCalcY) ? {2'b00, sw_q[7:4], 5'b00001}
                                     : {2'b00, sw_q[3:0], 5'b00001};
        step    = {9'd0, speed_q} + 11'd1;
        sum     = cur_pos + step;
        nxt_pos = cur_pos[9:0];
        nxt_dir = cur_dir;
        if (!mode_q) begin
            nxt_pos = (man_pos > max_pos) ? max_pos[9:0] : man_pos[9:0];
        end else if (cur_dir) begin
`ifdef SPRITE_WRAP_EN
            nxt_pos = (sum > max_pos) ? 10'd0 : sum[9:0];
`else
            if (sum >= max_pos) begin
                nxt_pos = max_pos[9:0];
                nxt_dir = 1'b0;
            end else begin
                nxt_pos = sum[9:0];
            end
`endif
        end else begin
`ifdef SPRITE_WRAP_EN
            nxt_pos = (cur_pos < step) ? max_pos[9:0] : 10'(cur_pos - step);
`else
            if (cur_pos <= step) begin
                nxt_pos = 10'd0;
                nxt_dir = 1'b1;
            end else begin
                nxt_pos = 10'(cur_pos - step);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= StWait;
            vc_q    <= 10'd0;
            fcnt    <= 4'd0;
            mode_q  <= 1'b0;
            speed_q <= 2'd0;
            sw_q    <= 8'd0;
            x_sh    <= 10'd0;
            y_sh    <= 10'd0;
            dx_sh   <= 1'b1;
            dy_sh   <= 1'b1;
            x_org_q <= 10'd0;
            y_org_q <= 10'd0;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
            upd_q   <= 1'b0;
        end else begin
            vc_q  <= bus.vc;
            upd_q <= 1'b0;
            case (state)
                StWait: begin
                    // A paused tick is swallowed without advancing the frame divider.
                    if (tick && !bus.pause) begin
                        if (fcnt == bus.fdiv) begin
                            fcnt    <= 4'd0;
                            mode_q  <= bus.mode;
                            speed_q <= bus.speed;
                            sw_q    <= bus.sw;
                            state   <= StCalcX;
                        end else begin
                            fcnt <= fcnt + 4'd1;
                        end
                    end
                end
                StCalcX: begin
                    x_sh  <= nxt_pos;
                    dx_sh <= nxt_dir;
                    state <= StCalcY;
                end
                StCalcY: begin
                    y_sh  <= nxt_pos;
                    dy_sh <= nxt_dir;
                    state <= StCommit;
                end
                StCommit: begin
                    x_org_q <= x_sh;
                    y_org_q <= y_sh;
                    dir_x_q <= dx_sh;
                    dir_y_q <= dy_sh;
                    upd_q   <= 1'b1;
                    state   <= StWait;
                end
                default: state <= StWait;
            endcase
        end
    end

    assign bus.x_org = x_org_q;
    assign bus.y_org = y_org_q;
    assign bus.dir_x = dir_x_q;
    assign bus.dir_y = dir_y_q;
    assign bus.upd   = upd_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: stimulus queues expected commits, a monitor checks upd.
module tb_sprite_motion_ctrl;

    logic clk = 1'b0;
    logic clr;
    int   cyc = 0;
    int   tick_cyc = 0;
    int   nchk = 0;
    int   nfail = 0;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       dx;
        logic       dy;
    } exp_t;

    exp_t q[$];

    sprite_motion_ctrl_if bus ();

    sprite_motion_ctrl dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push(input int x, input int y, input bit dx, input bit dy);
        exp_t e;
        e.x  = 10'(x);
        e.y  = 10'(y);
        e.dx = dx;
        e.dy = dy;
        q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x"}, 32'(bus.x_org), 0);
        check({tag, "_y"}, 32'(bus.y_org), 0);
        check({tag, "_dx"}, 32'(bus.dir_x), 1);
        check({tag, "_dy"}, 32'(bus.dir_y), 1);
        check({tag, "_upd"}, 32'(bus.upd), 0);
    endtask

    // One short blanking event; optionally pulse clr during the CALC_Y cycle.
    task automatic frame(input bit clr_mid);
        @(posedge clk); #1 bus.vc = 10'd510;
        @(posedge clk); #1 bus.vc = 10'd511; tick_cyc = cyc;
        if (clr_mid) begin
            @(posedge clk);
            @(posedge clk);
            #1 clr = 1'b1; bus.vc = 10'd0;
            repeat (2) @(posedge clk);
            #1 clr = 1'b0;
        end
        repeat (6) @(posedge clk);
        #1 bus.vc = 10'd0;
        @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (bus.upd === 1'b1) begin
            if (q.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL unexpected_upd: got upd=1 at cycle %0d, required no update", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("upd_x", 32'(bus.x_org), 32'(e.x));
                check("upd_y", 32'(bus.y_org), 32'(e.y));
                check("upd_dx", 32'(bus.dir_x), 32'(e.dx));
                check("upd_dy", 32'(bus.dir_y), 32'(e.dy));
                check("upd_latency", 32'(cyc - tick_cyc), 4);
            end
        end
    end

    initial begin
        int ex, ey;
        bit edx;
        clr = 1'b1;
        bus.vc = 10'd0;
        bus.mode = 1'b0;
        bus.pause = 1'b0;
        bus.speed = 2'd0;
        bus.fdiv = 4'd0;
        bus.sw = 8'd0;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        clr = 1'b0;
        bus.mode = 1'b1;

        push(1, 1, 1, 1);
        for (int v = 0; v <= 511; v++) begin
            @(posedge clk); #1 bus.vc = 10'(v);
            if (v == 511) tick_cyc = cyc;
        end
        repeat (6) @(posedge clk);
        #1 bus.vc = 10'd0;
        @(posedge clk);

        bus.mode = 1'b0;
        bus.sw = 8'hFF; push(400, 320, 1, 1); frame(0);
        bus.sw = 8'h21; push(33, 65, 1, 1);   frame(0);
        bus.sw = 8'h0C; push(385, 1, 1, 1);   frame(0);

        bus.mode = 1'b1;
        bus.speed = 2'd0;
`ifdef SPRITE_WRAP_EN
        for (int i = 0; i < 14; i++) begin
            push(386 + i, 2 + i, 1, 1);
            frame(0);
        end
        bus.speed = 2'd1; push(0, 17, 1, 1); frame(0);
        edx = 1'b1;
`else
        for (int i = 0; i < 11; i++) begin
            push(386 + i, 2 + i, 1, 1);
            frame(0);
        end
        bus.speed = 2'd3;
        push(400, 16, 0, 1); frame(0);
        push(396, 20, 0, 1); frame(0);
        edx = 1'b0;
`endif

        bus.mode = 1'b0;
        bus.sw = 8'h55; push(161, 161, edx, 1); frame(0);
        bus.mode = 1'b1;
        bus.speed = 2'd0;
        ex = 161;
        ey = 161;

        bus.fdiv = 4'd2;
        for (int f = 1; f <= 6; f++) begin
            if (f % 3 == 0) begin
                ex = edx ? ex + 1 : ex - 1;
                ey = ey + 1;
                push(ex, ey, edx, 1);
            end
            frame(0);
        end

        bus.pause = 1'b1;
        for (int f = 0; f < 3; f++) frame(0);
        check("pause_hold_x", 32'(bus.x_org), 32'(ex));
        check("pause_hold_y", 32'(bus.y_org), 32'(ey));
        bus.pause = 1'b0;
        bus.fdiv = 4'd0;
        ex = edx ? ex + 1 : ex - 1;
        ey = ey + 1;
        push(ex, ey, edx, 1);
        frame(0);

        frame(1);
        check_reset_outputs("clr_mid");
        push(1, 1, 1, 1);
        frame(0);

        repeat (4) @(posedge clk);
        check("pending_upd", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/sprite_motion_ctrl.md
# sprite_motion_ctrl

- Schedules the origin (top-left corner) of the 240x160 ROM sprite on the 640x480 VGA screen.
- Sits between the VGA timing counters and the sprite pixel/ROM-address datapath.
- Once per vertical blanking interval it computes a new origin: either bouncing automatically or taken from the switches. The new origin is committed atomically, so the datapath never sees it change mid-frame.

## Interface

Parameters:

- HBP, 144: horizontal back porch offset in the hc count
- VBP, 31: vertical back porch offset in the vc count
- HACT, 640: active pixels per line
- VACT, 480: active lines per frame
- W, 240: sprite width
- H, 160: sprite height

Ports:

- clk  in  1  pixel clock (25 MHz). One clock; reset is synchronous and active-high.
- clr  in  1  synchronous active-high reset
- vc  in  10  vertical counter from the VGA sync block
- mode  in  1  0 = manual (switch) position, 1 = auto bounce
- pause  in  1  1 = hold the current position
- speed  in  2  auto step per move = speed+1 pixels (1..4)
- fdiv  in  4  move once every fdiv+1 frames
- sw  in  8  manual position: sw[3:0] column, sw[7:4] row
- x_org  out  10  committed sprite column offset, 0..HACT-W
- y_org  out  10  committed sprite row offset, 0..VACT-H
- dir_x  out  1  1 = moving right
- dir_y  out  1  1 = moving down
- upd  out  1  one-cycle pulse when x_org/y_org change register

## Operation

- Frame tick:
  - vc is registered into vc_q.
  - tick = (vc == VBP+VACT) && (vc_q != vc).
  - This gives exactly one pulse per frame, on the first cycle of the first blank line.
- Frame divider:
  - fcnt (4 bits) is compared against fdiv on each tick.
  - If fcnt == fdiv: fcnt <= 0 and the move sequence starts.
  - Otherwise: fcnt increments and nothing else happens.
- pause = 1 at a tick:
  - The tick is consumed: no sequence, no upd.
  - fcnt holds its value.
- FSM states: WAIT, CALC_X, CALC_Y, COMMIT.
  - WAIT -> CALC_X on an accepted tick. mode, speed and sw are latched at this point.
  - CALC_X -> CALC_Y -> COMMIT -> WAIT, unconditionally, one cycle each.
- Manual mode:
  - nx = {1'b0, sw[3:0], 5'b00001}, ny = {1'b0, sw[7:4], 5'b00001}.
  - Each is clamped to XMAX = HACT-W (400) or YMAX = VACT-H (320).
  - dir_x and dir_y are unchanged.
- Auto mode, per axis, with step s = speed+1 and 11-bit arithmetic (no overflow):
  - dir = 1: if pos+s >= MAX, then pos <= MAX and dir <= 0; else pos <= pos+s.
  - dir = 0: if pos <= s, then pos <= 0 and dir <= 1; else pos <= pos-s.
- CALC_X computes the next x into a shadow register; CALC_Y computes the next y.
- COMMIT copies both shadows to x_org/y_org and asserts upd for one cycle.
  - upd fires even when the values are unchanged.
- A tick arriving while not in WAIT is ignored. This cannot occur in normal timing.
- clr at any point, including mid-sequence, forces every register to its reset value and the FSM to WAIT. No partial commit occurs.

## Timing

- Reset values: x_org = 0, y_org = 0, dir_x = 1, dir_y = 1, upd = 0, fcnt = 0, vc_q = 0, state WAIT.
- Latency: vc reaches VBP+VACT at edge t, so the tick is seen in cycle t.
  - CALC_X at t+1, CALC_Y at t+2, COMMIT at t+3.
  - x_org/y_org/upd update at the edge ending t+3.
- Outputs change only during vertical blanking. Commit completes ≤4 cycles after blank start, well before the next active line.
- mode, speed, sw and pause are sampled only at the tick cycle. Changes at other times take effect next frame.

## Configuration

- SPRITE_WRAP_EN defined: auto mode wraps instead of bouncing.
  - dir = 1: pos+s > MAX gives pos <= 0.
  - dir = 0: pos < s gives pos <= MAX.
  - dir_x and dir_y never toggle in auto mode.
- SPRITE_WRAP_EN undefined: bounce behaviour as specified in Operation.

## Test plan

- Reset: assert clr for 2 cycles -> x_org = 0, y_org = 0, dir_x = 1, dir_y = 1, upd = 0. Release, then a vc sweep to 511 -> exactly one upd, 4 cycles after vc = 511.
- Auto bounce: mode = 1, speed = 3, fdiv = 0, x_org starting at 396 -> next frame x_org = 400 and dir_x = 0; following frame x_org = 396.
- Manual clamp: mode = 0, sw = 8'hFF at the tick -> x_org = 400, y_org = 320. sw = 8'h21 -> x_org = 33, y_org = 65.
- Divider/pause: fdiv = 2 -> upd on every third frame only. pause = 1 for 3 frames -> no upd, positions held.
- clr mid-sequence: clr asserted in the CALC_Y cycle -> no upd, outputs at reset values, next frame resumes normally.
- SPRITE_WRAP_EN: dir_x = 1, x_org = 399, speed = 1 -> x_org = 0 and dir_x stays 1.
